// File: rtl/stage4_exp_sum_buffer.sv
// Softmax stage 4: accumulates the exact 2^x sum per vector while buffering elements,
// then replays each element tagged with the vector sum from a ping-pong bank pair.
module stage4_exp_sum_buffer #(
    parameter int VEC_LEN = 64,
    parameter int CNT_W   = $clog2(VEC_LEN),
    parameter int SUM_W   = 16 + CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_in,
    input  logic [15:0]      pow_in,
    input  logic [15:0]      x_in,
    output logic             valid_out,
    output logic [15:0]      pow_out,
    output logic [15:0]      x_out,
    output logic [SUM_W-1:0] sum_out,
    output logic [CNT_W-1:0] idx_out,
    output logic             last_out
);

    typedef enum logic {IDLE, REPLAY} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    state_t           state, state_n;
    logic [31:0]      mem [0:2*VEC_LEN-1];
    logic             wr_bank;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt, rd_cnt_n;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] sum_hold;
    logic [31:0]      rd_word;
    logic             accept, complete, emit;

    function automatic logic [SUM_W-1:0] acc_add(input logic [SUM_W-1:0] a,
                                                 input logic [15:0] p);
        return a + SUM_W'(p);
    endfunction

    assign accept   = en & valid_in;
    assign complete = accept & (wr_cnt == LAST_IDX);
    assign emit     = en & (state == REPLAY);
    // The replay bank is always the one not currently being filled.
    assign rd_word  = mem[{~wr_bank, rd_cnt}];

    always_comb begin
        state_n  = state;
        rd_cnt_n = rd_cnt;
        if (complete) begin
            state_n  = REPLAY;
            rd_cnt_n = '0;
        end else if (emit) begin
            rd_cnt_n = rd_cnt + CNT_W'(1);
            if (rd_cnt == LAST_IDX)
                state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rd_cnt <= '0;
        end else if (en) begin
            state  <= state_n;
            rd_cnt <= rd_cnt_n;
        end
    end

    // Fill side: accumulate and count accepted elements.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank  <= 1'b0;
            wr_cnt   <= '0;
            acc      <= '0;
            sum_hold <= '0;
        end else if (accept) begin
            if (complete) begin
                sum_hold <= acc_add(acc, pow_in);
                acc      <= '0;
                wr_cnt   <= '0;
                wr_bank  <= ~wr_bank;
            end else begin
                acc    <= acc_add(acc, pow_in);
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[{wr_bank, wr_cnt}] <= {pow_in, x_in};
    end

    // Replay output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            pow_out   <= '0;
            x_out     <= '0;
            sum_out   <= '0;
            idx_out   <= '0;
        end else if (en) begin
            valid_out <= emit;
            last_out  <= emit & (rd_cnt == LAST_IDX);
            if (emit) begin
                pow_out <= rd_word[31:16];
                x_out   <= rd_word[15:0];
                sum_out <= sum_hold;
                idx_out <= rd_cnt;
            end
        end
    end

endmodule

// File: tb/tb_stage4_exp_sum_buffer.sv
// Bench for stage4_exp_sum_buffer: directed scenarios plus random traffic,
// checked every cycle against a queue-based vector model.
module tb_stage4_exp_sum_buffer;

    localparam int VEC_LEN = 4;
    localparam int CNT_W   = 2;
    localparam int SUM_W   = 18;

    logic             clk, rst, en, valid_in;
    logic [15:0]      pow_in, x_in;
    logic             valid_out, last_out;
    logic [15:0]      pow_out, x_out;
    logic [SUM_W-1:0] sum_out;
    logic [CNT_W-1:0] idx_out;

    stage4_exp_sum_buffer #(.VEC_LEN(VEC_LEN)) dut (
        .clk(clk), .rst(rst), .en(en), .valid_in(valid_in),
        .pow_in(pow_in), .x_in(x_in),
        .valid_out(valid_out), .pow_out(pow_out), .x_out(x_out),
        .sum_out(sum_out), .idx_out(idx_out), .last_out(last_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      pow;
        logic [15:0]      x;
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] idx;
    } ent_t;

    ent_t             outq[$];
    logic [31:0]      part[$];
    logic [SUM_W-1:0] sums_log[$];

    logic             exp_valid, exp_last;
    logic [15:0]      exp_pow, exp_x;
    logic [SUM_W-1:0] exp_sum;
    logic [CNT_W-1:0] exp_idx;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Model: completed vectors become a queue of outputs, one drained per enabled cycle.
    task automatic model_edge(input logic r, input logic e, input logic v,
                              input logic [15:0] p, input logic [15:0] x);
        ent_t ent;
        int   s;
        if (r) begin
            part.delete();
            outq.delete();
            exp_valid = 0; exp_last = 0; exp_pow = 0; exp_x = 0; exp_sum = 0; exp_idx = 0;
        end else if (e) begin
            if (outq.size() > 0) begin
                ent = outq.pop_front();
                exp_valid = 1;
                exp_last  = (int'(ent.idx) == VEC_LEN - 1);
                exp_pow   = ent.pow;
                exp_x     = ent.x;
                exp_sum   = ent.sum;
                exp_idx   = ent.idx;
            end else begin
                exp_valid = 0;
                exp_last  = 0;
            end
            if (v) begin
                part.push_back({p, x});
                if (part.size() == VEC_LEN) begin
                    s = 0;
                    foreach (part[i]) s += int'(part[i][31:16]);
                    sums_log.push_back(SUM_W'(s));
                    foreach (part[i]) begin
                        ent.pow = part[i][31:16];
                        ent.x   = part[i][15:0];
                        ent.sum = SUM_W'(s);
                        ent.idx = CNT_W'(i);
                        outq.push_back(ent);
                    end
                    part.delete();
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic v,
                        input logic [15:0] p, input logic [15:0] x);
        rst = r; en = e; valid_in = v; pow_in = p; x_in = x;
        model_edge(r, e, v, p, x);
        @(posedge clk);
        #1;
        chk("valid_out", 32'(valid_out), 32'(exp_valid));
        chk("last_out",  32'(last_out),  32'(exp_last));
        chk("pow_out",   32'(pow_out),   32'(exp_pow));
        chk("x_out",     32'(x_out),     32'(exp_x));
        chk("sum_out",   32'(sum_out),   32'(exp_sum));
        chk("idx_out",   32'(idx_out),   32'(exp_idx));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 16'h0, 16'h0);
    endtask

    logic [SUM_W-1:0] want_sums [7];

    initial begin
        rst = 1; en = 0; valid_in = 0; pow_in = 0; x_in = 0;
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 16'h1234, 16'h5678);

        // Single vector
        step(0, 1, 1, 16'h0400, 16'hA000);
        step(0, 1, 1, 16'h0200, 16'hA001);
        step(0, 1, 1, 16'h0100, 16'hA002);
        step(0, 1, 1, 16'h0080, 16'hA003);
        chk("s1_no_early_valid", 32'(valid_out), 32'h0);
        idle(1);
        chk("s1_first_sum", 32'(sum_out), 32'h780);
        chk("s1_first_pow", 32'(pow_out), 32'h0400);
        chk("s1_first_valid", 32'(valid_out), 32'h1);
        idle(2);
        chk("s1_no_last_idx2", 32'(last_out), 32'h0);
        idle(1);
        chk("s1_last_idx3", 32'(last_out), 32'h1);
        idle(2);

        // Back-to-back vectors
        for (int i = 0; i < 4; i++) step(0, 1, 1, 16'hFFFF, 16'(16'hB000 + i));
        for (int i = 0; i < 4; i++) step(0, 1, 1, 16'h0001, 16'(16'hC000 + i));
        chk("s2_b2b_sumA", 32'(sum_out), 32'h3FFFC);
        idle(4);
        chk("s2_b2b_sumB", 32'(sum_out), 32'h4);
        idle(2);

        // Input gaps
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 16'h0400, 16'(16'hD000 + i));
            if (i < 3) step(0, 1, 0, 16'hFFFF, 16'hFFFF);
        end
        idle(1);
        chk("s3_gap_sum", 32'(sum_out), 32'h1000);
        idle(4);

        // Stall during replay at idx 1
        for (int i = 0; i < 4; i++) step(0, 1, 1, 16'(16'h0011 * (i + 1)), 16'(16'hE000 + i));
        idle(2);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 16'h7777, 16'h7777);
            chk("s4_stall_idx", 32'(idx_out), 32'h1);
        end
        idle(1);
        chk("s4_resume_idx", 32'(idx_out), 32'h2);
        idle(3);

        // Reset mid-fill
        step(0, 1, 1, 16'h0100, 16'hF000);
        step(0, 1, 1, 16'h0100, 16'hF001);
        step(1, 1, 0, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 16'h0010, 16'(16'h1100 + i));
        idle(1);
        chk("s5_sum_after_rst", 32'(sum_out), 32'h40);
        idle(4);

        // Reset mid-replay
        for (int i = 0; i < 4; i++) step(0, 1, 1, 16'h0020, 16'(16'h2200 + i));
        idle(3);
        step(1, 1, 0, 16'h0, 16'h0);
        chk("s6_rst_valid", 32'(valid_out), 32'h0);
        idle(3);
        chk("s6_no_resume", 32'(valid_out), 32'h0);

        // Pin the model's vector sums to hand-computed values
        want_sums = '{18'h780, 18'h3FFFC, 18'h4, 18'h1000, 18'hAA, 18'h40, 18'h80};
        chk("model_nsums", 32'(sums_log.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            if (i < sums_log.size()) chk("model_sum", 32'(sums_log[i]), 32'(want_sums[i]));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, e, v;
            logic [15:0] p;
            r = ($urandom_range(0, 249) == 0);
            e = ($urandom_range(0, 9) < 8);
            v = ($urandom_range(0, 9) < 7);
            p = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            step(r, e, v, p, 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
